// File: rtl/uart_rx_core_if.sv
// Consumer-side bundle of the UART receiver: byte output, valid/ack handshake and status.
interface uart_rx_core_if;
    logic       read_en;
    logic [7:0] read_data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  read_en,
        output read_data,
        output data_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output read_en,
        input  read_data,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver, LSB first: synchronised input, mid-bit start validation,
// centre sampling, one-byte holding register with valid/ack, framing-error and overrun flags.
module uart_rx_core #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned HALF_DIV = 2604
) (
    input  logic            clk_50M,
    input  logic            rst_n,
    input  logic            uart_rxd,
    uart_rx_core_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_rxd_s;
    logic             r_rxd_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_next;
    logic             w_good;
    logic             w_ferr;
    logic [7:0]       r_read_data;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    // Two-flop synchroniser plus one delay flop for falling-edge detection; idle level is high.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_rxd_s <= r_sync1;
            r_rxd_d <= r_rxd_s;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shreg   <= w_shreg_next;
        end
    end

    // Next state; the bit counter restarts on every state entry and at each data-bit boundary.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shreg_next   = r_shreg;
        w_good         = 1'b0;
        w_ferr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (r_rxd_d && !r_rxd_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_next = '0;
                    if (!r_rxd_s) begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next     = '0;
                    w_shreg_next   = {r_rxd_s, r_shreg[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_next = '0;
                    if (r_rxd_s) begin
                        w_good       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                w_cnt_next = '0;
                if (r_rxd_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Holding register and status; a completing frame takes priority over the consumer ack.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data  <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_busy      <= (w_state_next != S_IDLE);
            if (w_good) begin
                r_read_data  <= r_shreg;
                r_data_valid <= 1'b1;
                if (r_data_valid && !bus.read_en) begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.read_en && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign bus.read_data  = r_read_data;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a shortened bit period and an expected-byte queue.
module tb_uart_rx_core;

    localparam int unsigned BAUD = 16;
    localparam int unsigned HALF = 8;

    logic clk_50M;
    logic rst_n;
    logic uart_rxd;

    uart_rx_core_if u_if ();

    uart_rx_core #(
        .BAUD_DIV (BAUD),
        .HALF_DIV (HALF)
    ) u_dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .uart_rxd (uart_rxd),
        .bus      (u_if)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc       = 0;
    int rise_cyc  = 0;
    int ferr_cnt  = 0;
    int busy_cyc  = 0;
    int start_cyc = 0;
    logic dv_q = 1'b0;
    logic [7:0] exp_q[$];

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        cyc  <= cyc + 1;
        dv_q <= u_if.data_valid;
        if (u_if.data_valid && !dv_q) rise_cyc <= cyc;
        if (u_if.frame_err)           ferr_cnt <= ferr_cnt + 1;
        if (u_if.busy)                busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rxd  = 1'b0;
        start_cyc = cyc;
        repeat (BAUD) @(negedge clk_50M);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (BAUD) @(negedge clk_50M);
        end
        uart_rxd = stop;
        repeat (BAUD) @(negedge clk_50M);
    endtask

    task automatic expect_byte(input string tag);
        logic [7:0] e;
        int         w;
        w = 0;
        while (!u_if.data_valid && w < 4 * BAUD) begin
            @(negedge clk_50M);
            w++;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(u_if.data_valid), 32'(1));
        check({tag, "_data"}, 32'(u_if.read_data), 32'(e));
    endtask

    task automatic ack();
        u_if.read_en = 1'b1;
        @(negedge clk_50M);
        u_if.read_en = 1'b0;
    endtask

    initial begin
        int f0;
        int b0;
        rst_n        = 1'b0;
        uart_rxd     = 1'b1;
        u_if.read_en = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("rst_data",    32'(u_if.read_data),  32'(0));
        check("rst_valid",   32'(u_if.data_valid), 32'(0));
        check("rst_ferr",    32'(u_if.frame_err),  32'(0));
        check("rst_overrun", 32'(u_if.overrun),    32'(0));
        check("rst_busy",    32'(u_if.busy),       32'(0));
        rst_n = 1'b1;
        repeat (2000) @(negedge clk_50M);
        check("idle_busy_cycles", 32'(busy_cyc), 32'(0));

        // Single good byte, latency and ack
        f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        expect_byte("a5");
        check("a5_latency_ok", 32'((rise_cyc - start_cyc) >= 153 && (rise_cyc - start_cyc) <= 156), 32'(1));
        check("a5_no_ferr", 32'(ferr_cnt - f0), 32'(0));
        ack();
        check("a5_ack_valid", 32'(u_if.data_valid), 32'(0));
        check("a5_data_hold", 32'(u_if.read_data), 32'(8'hA5));
        ack();
        check("ack_idle_valid", 32'(u_if.data_valid), 32'(0));

        // Short low glitch rejected at start-bit centre
        b0 = busy_cyc;
        f0 = ferr_cnt;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk_50M);
        uart_rxd = 1'b1;
        repeat (HALF + 8) @(negedge clk_50M);
        check("glitch_busy_seen", 32'(busy_cyc > b0), 32'(1));
        check("glitch_busy_end",  32'(u_if.busy), 32'(0));
        check("glitch_valid",     32'(u_if.data_valid), 32'(0));
        check("glitch_ferr",      32'(ferr_cnt - f0), 32'(0));

        // Framing error with line held low, then recovery
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (3 * BAUD) @(negedge clk_50M);
        check("ferr_pulses",   32'(ferr_cnt - f0), 32'(1));
        check("ferr_busy_low", 32'(u_if.busy), 32'(1));
        check("ferr_valid",    32'(u_if.data_valid), 32'(0));
        check("ferr_data",     32'(u_if.read_data), 32'(8'hA5));
        uart_rxd = 1'b1;
        repeat (6) @(negedge clk_50M);
        check("ferr_busy_release", 32'(u_if.busy), 32'(0));
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        expect_byte("x81");
        check("x81_overrun", 32'(u_if.overrun), 32'(0));
        ack();

        // Back-to-back frames without ack -> overrun
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        expect_byte("x11");
        check("x11_overrun", 32'(u_if.overrun), 32'(0));
        send_frame(8'h22, 1'b1);
        expect_byte("x22");
        check("x22_overrun", 32'(u_if.overrun), 32'(1));
        ack();
        check("ovr_ack_valid",   32'(u_if.data_valid), 32'(0));
        check("ovr_ack_overrun", 32'(u_if.overrun), 32'(0));

        // Reset in the middle of bit 4 of 0xFF
        uart_rxd = 1'b0;
        repeat (BAUD) @(negedge clk_50M);
        uart_rxd = 1'b1;
        repeat (4 * BAUD + HALF) @(negedge clk_50M);
        check("mid_busy", 32'(u_if.busy), 32'(1));
        rst_n = 1'b0;
        @(negedge clk_50M);
        check("mrst_data",  32'(u_if.read_data),  32'(0));
        check("mrst_valid", 32'(u_if.data_valid), 32'(0));
        check("mrst_busy",  32'(u_if.busy),       32'(0));
        rst_n = 1'b1;
        repeat (3 * BAUD) @(negedge clk_50M);
        check("mrst_idle_busy", 32'(u_if.busy), 32'(0));
        f0 = ferr_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        expect_byte("x5a");
        check("x5a_no_ferr", 32'(ferr_cnt - f0), 32'(0));
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
